// File: rtl/mult_cell_rr_arbiter.sv
// mult_cell_rr_arbiter: round-robin share of one 3-partial multiplier cell, low-32 product to a valid/ready response port
module mult_cell_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [31:0]           cell_src1,
  output logic [31:0]           cell_src2,
  output logic                  cell_en,
  input  logic [31:0]           cell_p1,
  input  logic [31:0]           cell_p2,
  input  logic [31:0]           cell_p3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic [CNT_W-1:0]      op_count
);
  logic [ID_W-1:0] rr_ptr, grant, m_id;
  logic            m_valid, out_free, m_adv, found, fire;
  assign out_free = ~rsp_valid | rsp_ready;
  assign m_adv    = ~m_valid | out_free;
  assign cell_en  = m_adv;
  assign fire     = m_adv & found;
  // Scan starts one past the last grant so the previous winner has lowest priority.
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        grant = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
  assign req_ready = fire ? (NUM_REQ'(1) << grant) : '0;
  assign cell_src1 = fire ? req_a[int'(grant)*32 +: 32] : 32'd0;
  assign cell_src2 = fire ? req_b[int'(grant)*32 +: 32] : 32'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      m_valid   <= 1'b0;
      m_id      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      if (fire) rr_ptr <= grant;
      if (m_adv) begin
        m_valid <= fire;
        m_id    <= grant;
      end
      if (out_free) begin
        rsp_valid <= m_valid;
        if (m_valid) begin
          rsp_data <= cell_p1 + ((cell_p2 + cell_p3) << 16);
          rsp_id   <= m_id;
        end
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mult_cell_rr_arbiter.sv
// tb_mult_cell_rr_arbiter: directed checks of arbitration, recombination, backpressure and reset
module tb_mult_cell_rr_arbiter;
  logic         clk = 0, reset = 1, rsp_ready = 1, cell_en, rsp_valid;
  logic [3:0]   req_valid = 0, req_ready;
  logic [127:0] req_a = 0, req_b = 0;
  logic [31:0]  cell_src1, cell_src2, rsp_data;
  logic [31:0]  cell_p1 = 0, cell_p2 = 0, cell_p3 = 0;
  logic [1:0]   rsp_id;
  logic [31:0]  op_count;
  int tests = 0, fails = 0;
  mult_cell_rr_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cell_src1(cell_src1), .cell_src2(cell_src2),
    .cell_en(cell_en), .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .op_count(op_count)
  );
  always #5 clk = ~clk;
  // Behavioural multiplier cell: registered, enable-gated 16x16 partials.
  always @(posedge clk) if (cell_en) begin
    cell_p1 <= cell_src1[15:0]  * cell_src2[15:0];
    cell_p2 <= cell_src1[15:0]  * cell_src2[31:16];
    cell_p3 <= cell_src1[31:16] * cell_src2[15:0];
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic single(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int cnt);
    req_valid = 4'b1 << r;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b1 << r);
    chk("single_src1", cell_src1, a);
    chk("single_src2", cell_src2, b);
    chk("single_en", cell_en, 1);
    tick;
    req_valid = 0;
    @(negedge clk);
    chk("single_lat", rsp_valid, 0);
    tick;
    @(negedge clk);
    chk("single_valid", rsp_valid, 1);
    chk("single_data", rsp_data, exp);
    chk("single_id", rsp_id, r);
    tick;
    @(negedge clk);
    chk("single_cnt", op_count, cnt);
    chk("single_idle", rsp_valid, 0);
    tick;
  endtask
  initial begin
    tick;
    @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_cnt", op_count, 0);
    tick;
    reset = 0;
    single(0, 32'h00010003, 32'h00020005, 32'h000B000F, 1);
    single(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 2);
    single(3, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 3);
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'(i + 2);
      req_b[32*i +: 32] = 32'(i + 3);
    end
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = 0;
      @(negedge clk);
      if (k < 8) chk("rr_grant", req_ready, 4'b1 << (k % 4));
      if (k >= 2) begin
        chk("rr_valid", rsp_valid, 1);
        chk("rr_id", rsp_id, (k - 2) % 4);
        chk("rr_data", rsp_data, ((k - 2) % 4 + 2) * ((k - 2) % 4 + 3));
      end
      tick;
    end
    @(negedge clk);
    chk("rr_cnt", op_count, 11);
    chk("rr_idle", rsp_valid, 0);
    tick;
    rsp_ready = 0;
    req_a[31:0] = 7;
    req_b[31:0] = 6;
    req_a[63:32] = 32'h12345678;
    req_b[63:32] = 32'h00000010;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("bp_ready0", req_ready, 4'b0001);
    tick;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_ready1", req_ready, 4'b0010);
    tick;
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_en", cell_en, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 42);
      chk("bp_id", rsp_id, 0);
      tick;
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_rel_data0", rsp_data, 42);
    chk("bp_rel_id0", rsp_id, 0);
    tick;
    @(negedge clk);
    chk("bp_rel_valid1", rsp_valid, 1);
    chk("bp_rel_data1", rsp_data, 32'h23456780);
    chk("bp_rel_id1", rsp_id, 1);
    tick;
    @(negedge clk);
    chk("bp_idle", rsp_valid, 0);
    chk("bp_cnt", op_count, 13);
    tick;
    rsp_ready = 0;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rst_mid_g2", req_ready, 4'b0100);
    tick;
    req_valid = 4'b1000;
    @(negedge clk);
    chk("rst_mid_g3", req_ready, 4'b1000);
    tick;
    req_valid = 0;
    reset = 1;
    @(negedge clk);
    chk("rst_mid_pre", rsp_valid, 1);
    tick;
    reset = 0;
    rsp_ready = 1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_cnt", op_count, 0);
    chk("rst_mid_grant", req_ready, 4'b0001);
    tick;
    req_valid = 0;
    @(negedge clk);
    chk("rst_drop", rsp_valid, 0);
    tick;
    @(negedge clk);
    chk("rst_new_valid", rsp_valid, 1);
    chk("rst_new_id", rsp_id, 0);
    chk("rst_new_data", rsp_data, 42);
    tick;
    @(negedge clk);
    chk("rst_new_cnt", op_count, 1);
    chk("rst_new_idle", rsp_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
